// File: rtl/battleship_game_ctrl.sv
// Game-flow controller for Battleship: idle, ship placement, alternating player/PC turns, game over.
// Owns the per-turn countdown (seconds prescaler + seconds-left), placement and round counters.
module battleship_game_ctrl #(
  parameter int N_SHIPS       = 5,
  parameter int HP_W          = 3,
  parameter int TURN_SECS     = 15,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_W        = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               ship_placed,
  input  logic                               attack,
  input  logic                               pc_done,
  input  logic [HP_W-1:0]                    hp_pc,
  input  logic [HP_W-1:0]                    hp_player,
  output logic                               en_put_barcos,
  output logic                               en_move,
  output logic                               en_player_attack,
  output logic                               en_cont_seg,
  output logic                               en_pc_attack,
  output logic [$clog2(TURN_SECS+1)-1:0]     secs_left,
  output logic [$clog2(N_SHIPS+1)-1:0]       ships_placed,
  output logic [TURN_W-1:0]                  turn_count,
  output logic                               timeout,
  output logic                               game_over,
  output logic                               player_won
);

  localparam int SECS_W = $clog2(TURN_SECS+1);
  localparam int SHIP_W = $clog2(N_SHIPS+1);
  localparam int PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PLACE       = 3'd1,
    S_PLAYER_TURN = 3'd2,
    S_P_RESOLVE   = 3'd3,
    S_PC_TURN     = 3'd4,
    S_PC_RESOLVE  = 3'd5,
    S_GAME_OVER   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PRE_W-1:0]    r_presc;
  logic [SECS_W-1:0]   r_secs;
  logic [SHIP_W-1:0]   r_ships;
  logic [TURN_W-1:0]   r_turns;
  logic                r_won;
  logic                r_timeout;

  logic w_in_turn;
  logic w_tick;
  logic w_expire;
  logic w_enter_turn;
  logic w_clear;

  assign w_in_turn    = (r_state == S_PLAYER_TURN);
  assign w_tick       = w_in_turn && (r_presc == PRE_W'(TICKS_PER_SEC-1));
  assign w_expire     = w_tick && (r_secs == SECS_W'(1));
  assign w_enter_turn = (w_next == S_PLAYER_TURN) && !w_in_turn;
  // Counters are cleared while idle and when a finished game is restarted.
  assign w_clear      = (r_state == S_IDLE) || ((r_state == S_GAME_OVER) && start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_PLACE;
        else       w_next = S_IDLE;
      end
      S_PLACE: begin
        if (ship_placed && (r_ships == SHIP_W'(N_SHIPS-1))) w_next = S_PLAYER_TURN;
        else                                                 w_next = S_PLACE;
      end
      S_PLAYER_TURN: begin
        // A fire request on the expiry cycle takes priority over the timeout.
        if (attack)        w_next = S_P_RESOLVE;
        else if (w_expire) w_next = S_PC_TURN;
        else               w_next = S_PLAYER_TURN;
      end
      S_P_RESOLVE: begin
        if (hp_pc == {HP_W{1'b0}}) w_next = S_GAME_OVER;
        else                       w_next = S_PC_TURN;
      end
      S_PC_TURN: begin
        if (pc_done) w_next = S_PC_RESOLVE;
        else         w_next = S_PC_TURN;
      end
      S_PC_RESOLVE: begin
        if (hp_player == {HP_W{1'b0}}) w_next = S_GAME_OVER;
        else                           w_next = S_PLAYER_TURN;
      end
      S_GAME_OVER: begin
        if (start) w_next = S_PLACE;
        else       w_next = S_GAME_OVER;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= {PRE_W{1'b0}};
      r_secs  <= {SECS_W{1'b0}};
    end else if (w_enter_turn) begin
      r_presc <= {PRE_W{1'b0}};
      r_secs  <= SECS_W'(TURN_SECS);
    end else if (w_in_turn) begin
      if (w_tick || (w_next != S_PLAYER_TURN)) r_presc <= {PRE_W{1'b0}};
      else                                     r_presc <= r_presc + PRE_W'(1);
      if (w_tick) r_secs <= r_secs - SECS_W'(1);
      else        r_secs <= r_secs;
    end else begin
      r_presc <= {PRE_W{1'b0}};
      r_secs  <= r_secs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ships   <= {SHIP_W{1'b0}};
      r_turns   <= {TURN_W{1'b0}};
      r_won     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire && !attack;
      if (w_clear) begin
        r_ships <= {SHIP_W{1'b0}};
        r_turns <= {TURN_W{1'b0}};
        r_won   <= 1'b0;
      end else begin
        if ((r_state == S_PLACE) && ship_placed) r_ships <= r_ships + SHIP_W'(1);
        if ((r_state == S_PC_RESOLVE) && (hp_player != {HP_W{1'b0}}) &&
            (r_turns != {TURN_W{1'b1}}))
          r_turns <= r_turns + TURN_W'(1);
        if ((r_state == S_P_RESOLVE) && (hp_pc == {HP_W{1'b0}}))
          r_won <= 1'b1;
        else if ((r_state == S_PC_RESOLVE) && (hp_player == {HP_W{1'b0}}))
          r_won <= 1'b0;
      end
    end
  end

  assign en_put_barcos    = (r_state == S_PLACE);
  assign en_move          = (r_state == S_PLACE) || (r_state == S_PLAYER_TURN);
  assign en_player_attack = w_in_turn;
  assign en_cont_seg      = w_in_turn;
  assign en_pc_attack     = (r_state == S_PC_TURN);
  assign game_over        = (r_state == S_GAME_OVER);
  assign secs_left        = r_secs;
  assign ships_placed     = r_ships;
  assign turn_count       = r_turns;
  assign player_won       = r_won;
  assign timeout          = r_timeout;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed plus randomized bench for battleship_game_ctrl against a phase/elapsed-time reference model.
module tb_battleship_game_ctrl;

  localparam int N_SHIPS   = 3;
  localparam int HP_W      = 3;
  localparam int TURN_SECS = 2;
  localparam int TICKS     = 4;
  localparam int TURN_W    = 2;
  localparam int TURN_MAX  = (1 << TURN_W) - 1;

  localparam int P_IDLE = 0, P_PLACE = 1, P_PTURN = 2, P_PRES = 3, P_PC = 4, P_PCRES = 5, P_OVER = 6;

  logic clk = 1'b0;
  logic reset, start, ship_placed, attack, pc_done;
  logic [HP_W-1:0] hp_pc, hp_player;
  logic en_put_barcos, en_move, en_player_attack, en_cont_seg, en_pc_attack;
  logic [1:0] secs_left;
  logic [1:0] ships_placed;
  logic [TURN_W-1:0] turn_count;
  logic timeout, game_over, player_won;

  battleship_game_ctrl #(
    .N_SHIPS(N_SHIPS), .HP_W(HP_W), .TURN_SECS(TURN_SECS),
    .TICKS_PER_SEC(TICKS), .TURN_W(TURN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ship_placed(ship_placed),
    .attack(attack), .pc_done(pc_done), .hp_pc(hp_pc), .hp_player(hp_player),
    .en_put_barcos(en_put_barcos), .en_move(en_move),
    .en_player_attack(en_player_attack), .en_cont_seg(en_cont_seg),
    .en_pc_attack(en_pc_attack), .secs_left(secs_left),
    .ships_placed(ships_placed), .turn_count(turn_count), .timeout(timeout),
    .game_over(game_over), .player_won(player_won)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game phase plus cycles elapsed in the current player turn.
  int m_phase, m_elapsed, m_secs, m_ships, m_turns, m_won, m_timeout;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_secs = 0; m_ships = 0;
    m_turns = 0; m_won = 0; m_timeout = 0;
  endtask

  task automatic model_step();
    m_timeout = 0;
    case (m_phase)
      P_IDLE: begin
        m_ships = 0; m_turns = 0; m_won = 0;
        if (start) m_phase = P_PLACE;
      end
      P_PLACE: if (ship_placed) begin
        m_ships++;
        if (m_ships == N_SHIPS) begin
          m_phase = P_PTURN; m_elapsed = 0; m_secs = TURN_SECS;
        end
      end
      P_PTURN: begin
        m_elapsed++;
        m_secs = TURN_SECS - m_elapsed / TICKS;
        if (attack) m_phase = P_PRES;
        else if (m_elapsed == TURN_SECS * TICKS) begin
          m_phase = P_PC; m_timeout = 1;
        end
      end
      P_PRES: if (hp_pc == 0) begin m_phase = P_OVER; m_won = 1; end
              else m_phase = P_PC;
      P_PC: if (pc_done) m_phase = P_PCRES;
      P_PCRES: if (hp_player == 0) begin m_phase = P_OVER; m_won = 0; end
               else begin
                 m_phase = P_PTURN; m_elapsed = 0; m_secs = TURN_SECS;
                 if (m_turns < TURN_MAX) m_turns++;
               end
      P_OVER: if (start) begin
        m_phase = P_PLACE; m_ships = 0; m_turns = 0; m_won = 0;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en_put_barcos"}, int'(en_put_barcos), int'(m_phase == P_PLACE));
    chk({tag, ".en_move"}, int'(en_move), int'(m_phase == P_PLACE || m_phase == P_PTURN));
    chk({tag, ".en_player_attack"}, int'(en_player_attack), int'(m_phase == P_PTURN));
    chk({tag, ".en_cont_seg"}, int'(en_cont_seg), int'(m_phase == P_PTURN));
    chk({tag, ".en_pc_attack"}, int'(en_pc_attack), int'(m_phase == P_PC));
    chk({tag, ".game_over"}, int'(game_over), int'(m_phase == P_OVER));
    chk({tag, ".secs_left"}, int'(secs_left), m_secs);
    chk({tag, ".ships_placed"}, int'(ships_placed), m_ships);
    chk({tag, ".turn_count"}, int'(turn_count), m_turns);
    chk({tag, ".timeout"}, int'(timeout), m_timeout);
    chk({tag, ".player_won"}, int'(player_won), m_won);
  endtask

  task automatic cyc(input string tag, input logic st, input logic sp, input logic at,
                     input logic pd, input int hpc, input int hpp);
    start = st; ship_placed = sp; attack = at; pc_done = pd;
    hp_pc = HP_W'(hpc); hp_player = HP_W'(hpp);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5, 5);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  task automatic place_all(input string tag);
    for (int i = 0; i < N_SHIPS; i++) cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 5, 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ship_placed = 1'b0; attack = 1'b0; pc_done = 1'b0;
    hp_pc = 3'd5; hp_player = 3'd5;
    do_reset();

    // Start and place three ships.
    cyc("start", 1'b1, 1'b0, 1'b0, 1'b0, 5, 5);
    chk("place_entered", int'(en_put_barcos), 1);
    for (int i = 1; i <= N_SHIPS; i++) begin
      cyc("place", 1'b0, 1'b1, 1'b0, 1'b0, 5, 5);
      chk("ships_count", int'(ships_placed), i);
    end
    chk("turn_secs_init", int'(secs_left), 2);
    cyc("extra_ship", 1'b0, 1'b1, 1'b0, 1'b0, 5, 5);

    // Let the turn expire: one second left after 4 cycles, timeout after 8.
    for (int i = 2; i <= 4; i++) idle("wait");
    chk("secs_after4", int'(secs_left), 1);
    for (int i = 5; i <= 8; i++) idle("wait");
    chk("timeout_pulse", int'(timeout), 1);
    chk("pc_turn_en", int'(en_pc_attack), 1);
    cyc("start_in_play", 1'b1, 1'b0, 1'b0, 1'b0, 5, 5);
    chk("timeout_one_cycle", int'(timeout), 0);

    // PC finishes with player still alive: next round.
    cyc("pc_done", 1'b0, 1'b0, 1'b0, 1'b1, 5, 2);
    cyc("pc_resolve", 1'b0, 1'b0, 1'b0, 1'b0, 5, 2);
    chk("round1", int'(turn_count), 1);
    chk("secs_reload", int'(secs_left), 2);

    // Player sinks the last PC ship.
    cyc("attack", 1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
    cyc("p_resolve_win", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
    chk("won", int'(player_won), 1);
    chk("over", int'(game_over), 1);

    // Restart from GAME_OVER; attack on the expiry cycle beats the timeout.
    cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, 5, 5);
    chk("restart_cleared", int'(turn_count) + int'(ships_placed) + int'(player_won), 0);
    place_all("place2");
    for (int i = 1; i <= 7; i++) idle("wait2");
    cyc("attack_at_expiry", 1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
    chk("no_timeout_on_attack", int'(timeout), 0);
    cyc("p_resolve_miss", 1'b0, 1'b0, 1'b0, 1'b0, 3, 5);
    chk("to_pc_turn", int'(en_pc_attack), 1);

    // Asynchronous reset in PC_TURN takes effect before the next edge.
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    @(negedge clk); reset = 1'b0;

    // Five rounds with TURN_W=2 saturate the round counter at 3.
    cyc("start3", 1'b1, 1'b0, 1'b0, 1'b0, 5, 5);
    place_all("place3");
    for (int r = 0; r < 5; r++) begin
      cyc("r_attack", 1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
      cyc("r_pres", 1'b0, 1'b0, 1'b0, 1'b0, 4, 5);
      cyc("r_pcdone", 1'b0, 1'b0, 1'b0, 1'b1, 5, 5);
      cyc("r_pcres", 1'b0, 1'b0, 1'b0, 1'b0, 5, 4);
    end
    chk("turn_saturate", int'(turn_count), TURN_MAX);
    cyc("l_attack", 1'b0, 1'b0, 1'b1, 1'b0, 5, 5);
    cyc("l_pres", 1'b0, 1'b0, 1'b0, 1'b0, 4, 5);
    cyc("l_pcdone", 1'b0, 1'b0, 1'b0, 1'b1, 5, 5);
    cyc("l_pcres", 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    chk("lost_over", int'(game_over), 1);
    chk("lost_won", int'(player_won), 0);

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc("rand",
          logic'($urandom_range(0, 9) == 0),
          logic'($urandom_range(0, 2) == 0),
          logic'($urandom_range(0, 11) == 0),
          logic'($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
